// File: rtl/mat_sqrt_db_iter_if.sv
// Handshake/bus bundle for the Denman-Beavers sqrt engine
// and its link to the shared 3x3 inverse unit.
interface mat_sqrt_db_iter_if #(
  parameter int W = 33
);
  logic           i_start;
  logic [9*W-1:0] i_mat;
  logic           o_busy;
  logic           o_done;
  logic [1:0]     o_err;
  logic [3:0]     o_iters;
  logic [9*W-1:0] o_mat;
  logic           o_inv_req;
  logic [9*W-1:0] o_inv_y;
  logic [9*W-1:0] o_inv_z;
  logic           i_inv_ack;
  logic [9*W-1:0] i_inv_iy;
  logic [9*W-1:0] i_inv_iz;
  logic           i_inv_sing;

  modport slave (
    input  i_start, i_mat,
    input  i_inv_ack, i_inv_iy,
    input  i_inv_iz, i_inv_sing,
    output o_busy, o_done, o_err,
    output o_iters, o_mat,
    output o_inv_req, o_inv_y, o_inv_z
  );

  modport master (
    output i_start, i_mat,
    output i_inv_ack, i_inv_iy,
    output i_inv_iz, i_inv_sing,
    input  o_busy, o_done, o_err,
    input  o_iters, o_mat,
    input  o_inv_req, o_inv_y, o_inv_z
  );
endinterface

// File: rtl/mat_sqrt_db_iter.sv
// Denman-Beavers 3x3 matrix square root, iterating with an
// external shared inverse unit; early exit on convergence.
module mat_sqrt_db_iter #(
  parameter int W        = 33,
  parameter int FRAC     = 6,
  parameter int MAX_ITER = 4,
  parameter int TOL      = 1,
  parameter int INV_TMO  = 255
) (
  input logic               iclk,
  input logic               ireset,
  mat_sqrt_db_iter_if.slave io
);

  localparam int N = 9 * W;
  localparam logic [W-1:0] ONE = W'(1) << FRAC;
  localparam logic [W:0]   TOL_V = (W+1)'(TOL);
  localparam logic [3:0]   ITER_MAX = 4'(MAX_ITER);
  localparam logic [7:0]   TMO_LAST = 8'(INV_TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INV, S_UPD, S_CHK, S_DONE
  } st_t;

  st_t          r_st;
  st_t          w_nxt;
  logic [N-1:0] r_y;
  logic [N-1:0] r_z;
  logic [N-1:0] r_iy;
  logic [N-1:0] r_iz;
  logic [N-1:0] r_mat;
  logic [N-1:0] w_yn;
  logic [N-1:0] w_zn;
  logic [N-1:0] w_ident;
  logic [3:0]   r_iter;
  logic [3:0]   r_iters;
  logic [7:0]   r_tmo;
  logic [1:0]   r_err;
  logic [1:0]   w_err;
  logic [W:0]   r_delta;
  logic [W:0]   w_delta;
  logic [W:0]   w_ad [9];

  // Sums use W+1 bits; dropping the LSB is a floor halving.
  for (genvar k = 0; k < 9; k++) begin : g_el
    logic signed [W:0]   w_ys;
    logic signed [W:0]   w_zs;
    logic signed [W+1:0] w_df;
    logic signed [W+1:0] w_ng;

    assign w_ident[k*W +: W] =
      (k % 4 == 0) ? ONE : '0;
    assign w_ys =
      $signed({r_y[k*W+W-1], r_y[k*W +: W]})
      + $signed({r_iz[k*W+W-1], r_iz[k*W +: W]});
    assign w_zs =
      $signed({r_z[k*W+W-1], r_z[k*W +: W]})
      + $signed({r_iy[k*W+W-1], r_iy[k*W +: W]});
    assign w_yn[k*W +: W] = w_ys[W:1];
    assign w_zn[k*W +: W] = w_zs[W:1];
    assign w_df =
      $signed({{2{w_ys[W]}}, w_ys[W:1]})
      - $signed({{2{r_y[k*W+W-1]}}, r_y[k*W +: W]});
    assign w_ng = -w_df;
    assign w_ad[k] = w_df[W+1] ? w_ng[W:0] : w_df[W:0];
  end

  always_comb begin
    w_delta = '0;
    for (int k = 0; k < 9; k++)
      if (w_ad[k] > w_delta)
        w_delta = w_ad[k];
  end

  always_comb begin
    w_nxt = r_st;
    w_err = 2'b00;
    unique case (r_st)
      S_IDLE:
        if (io.i_start)
          w_nxt = S_INV;
      S_INV:
        if (io.i_inv_ack) begin
          w_nxt = io.i_inv_sing ? S_DONE : S_UPD;
          w_err = io.i_inv_sing ? 2'b01 : 2'b00;
        end else if (r_tmo == TMO_LAST) begin
          w_nxt = S_DONE;
          w_err = 2'b10;
        end
      S_UPD:
        w_nxt = S_CHK;
      S_CHK:
        if (r_delta <= TOL_V || r_iter == ITER_MAX)
          w_nxt = S_DONE;
        else
          w_nxt = S_INV;
      S_DONE:
        w_nxt = S_IDLE;
      default:
        w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      r_st    <= S_IDLE;
      r_y     <= '0;
      r_z     <= '0;
      r_iy    <= '0;
      r_iz    <= '0;
      r_mat   <= '0;
      r_iter  <= '0;
      r_iters <= '0;
      r_tmo   <= '0;
      r_err   <= '0;
      r_delta <= '0;
    end else begin
      r_st  <= w_nxt;
      r_tmo <= (r_st == S_INV) ? r_tmo + 8'd1 : 8'd0;
      if (r_st == S_IDLE && io.i_start) begin
        r_y    <= io.i_mat;
        r_z    <= w_ident;
        r_iter <= '0;
      end
      if (r_st == S_INV && io.i_inv_ack
          && !io.i_inv_sing) begin
        r_iy <= io.i_inv_iy;
        r_iz <= io.i_inv_iz;
      end
      if (r_st == S_UPD) begin
        r_y     <= w_yn;
        r_z     <= w_zn;
        r_delta <= w_delta;
        r_iter  <= r_iter + 4'd1;
      end
      // Result registers load as DONE is entered so they
      // are valid in the o_done cycle.
      if (w_nxt == S_DONE) begin
        r_mat   <= r_y;
        r_iters <= r_iter;
        r_err   <= w_err;
      end
    end
  end

  assign io.o_busy    = (r_st == S_INV) || (r_st == S_UPD)
                        || (r_st == S_CHK);
  assign io.o_done    = (r_st == S_DONE);
  assign io.o_inv_req = (r_st == S_INV);
  assign io.o_inv_y   = r_y;
  assign io.o_inv_z   = r_z;
  assign io.o_mat     = r_mat;
  assign io.o_iters   = r_iters;
  assign io.o_err     = r_err;

endmodule

// File: tb/tb_mat_sqrt_db_iter.sv
// Bench for mat_sqrt_db_iter: inverse-unit responder plus a
// real-arithmetic Denman-Beavers reference model.
module tb_mat_sqrt_db_iter;
  localparam int W = 33;
  localparam int FRAC = 6;
  localparam int MAX_ITER = 4;
  localparam int TOL = 1;
  localparam int INV_TMO = 255;
  localparam int N = 9 * W;

  logic iclk;
  logic ireset;
  int   checks;
  int   errors;
  int   lat;
  int   sing_at;
  int   hold_at;

  mat_sqrt_db_iter_if #(.W(W)) bus ();

  mat_sqrt_db_iter #(
    .W(W), .FRAC(FRAC), .MAX_ITER(MAX_ITER),
    .TOL(TOL), .INV_TMO(INV_TMO)
  ) dut (
    .iclk(iclk),
    .ireset(ireset),
    .io(bus.slave)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  function automatic longint el(input logic [N-1:0] m,
                                input int k);
    logic [W-1:0] v;
    v = m[k*W +: W];
    return longint'($signed(v));
  endfunction

  function automatic void put(inout logic [N-1:0] m,
                              input int k,
                              input longint v);
    m[k*W +: W] = v[W-1:0];
  endfunction

  function automatic longint floor_half(input longint s);
    return (s >= 0) ? s / 2 : -((-s + 1) / 2);
  endfunction

  function automatic logic [N-1:0] ident();
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < 3; i++) put(m, i * 4, 64);
    return m;
  endfunction

  // Exact inverse rounded to the nearest fixed-point LSB.
  function automatic logic [N-1:0] inv3(
      input logic [N-1:0] m, output bit sing);
    real a [9];
    real c [9];
    real det;
    logic [N-1:0] r;
    r = '0;
    for (int k = 0; k < 9; k++)
      a[k] = real'(el(m, k)) / 64.0;
    c[0] = a[4]*a[8] - a[5]*a[7];
    c[1] = -(a[3]*a[8] - a[5]*a[6]);
    c[2] = a[3]*a[7] - a[4]*a[6];
    c[3] = -(a[1]*a[8] - a[2]*a[7]);
    c[4] = a[0]*a[8] - a[2]*a[6];
    c[5] = -(a[0]*a[7] - a[1]*a[6]);
    c[6] = a[1]*a[5] - a[2]*a[4];
    c[7] = -(a[0]*a[5] - a[2]*a[3]);
    c[8] = a[0]*a[4] - a[1]*a[3];
    det = a[0]*c[0] + a[1]*c[1] + a[2]*c[2];
    sing = (det == 0.0);
    if (!sing)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          put(r, i*3 + j,
              longint'(c[j*3 + i] / det * 64.0));
    return r;
  endfunction

  function automatic void model(
      input  logic [N-1:0] a,
      input  int           s_at,
      input  int           h_at,
      output logic [N-1:0] res,
      output int           iters,
      output int           err);
    logic [N-1:0] y, z, iy, iz, yn, zn;
    bit s1, s2;
    longint d, ad;
    y = a;
    z = ident();
    iters = 0;
    err = 0;
    for (int it = 0; it < MAX_ITER; it++) begin
      if (it + 1 == h_at) begin
        err = 2;
        break;
      end
      iy = inv3(y, s1);
      iz = inv3(z, s2);
      if (s1 || s2 || it + 1 == s_at) begin
        err = 1;
        break;
      end
      d = 0;
      yn = '0;
      zn = '0;
      for (int k = 0; k < 9; k++) begin
        put(yn, k, floor_half(el(y, k) + el(iz, k)));
        put(zn, k, floor_half(el(z, k) + el(iy, k)));
        ad = el(yn, k) - el(y, k);
        if (ad < 0) ad = -ad;
        if (ad > d) d = ad;
      end
      y = yn;
      z = zn;
      iters++;
      if (d <= TOL) break;
    end
    res = y;
  endfunction

  // Shared inverse unit: acks after `lat` waiting cycles.
  initial begin : responder
    int  wcnt;
    int  nack;
    bit  s1, s2;
    wcnt = 0;
    nack = 0;
    bus.i_inv_ack = 1'b0;
    bus.i_inv_sing = 1'b0;
    bus.i_inv_iy = '0;
    bus.i_inv_iz = '0;
    forever begin
      @(negedge iclk);
      bus.i_inv_ack = 1'b0;
      bus.i_inv_sing = 1'b0;
      if (!bus.o_busy) nack = 0;
      if (!bus.o_inv_req) begin
        wcnt = 0;
      end else if (wcnt >= lat) begin
        if (nack + 1 != hold_at) begin
          bus.i_inv_iy = inv3(bus.o_inv_y, s1);
          bus.i_inv_iz = inv3(bus.o_inv_z, s2);
          bus.i_inv_sing = s1 || s2 || (nack + 1 == sing_at);
          bus.i_inv_ack = 1'b1;
          nack++;
          wcnt = 0;
        end
      end else begin
        wcnt++;
      end
    end
  end

  task automatic chk(input string tag,
                     input longint obs,
                     input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic chkm(input string tag,
                      input logic [N-1:0] obs,
                      input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Starts a job and returns the cycle of o_done (start = 0).
  task automatic run(input logic [N-1:0] a,
                     input logic [N-1:0] poke_m,
                     input int poke,
                     output int cyc,
                     output bit b1);
    bus.i_mat = a;
    bus.i_start = 1'b1;
    @(negedge iclk);
    bus.i_start = 1'b0;
    cyc = 1;
    b1 = bus.o_busy && bus.o_inv_req;
    while (!bus.o_done && cyc < 2000) begin
      if (cyc == poke) begin
        bus.i_mat = poke_m;
        bus.i_start = 1'b1;
      end else begin
        bus.i_start = 1'b0;
      end
      @(negedge iclk);
      cyc++;
    end
    bus.i_start = 1'b0;
  endtask

  task automatic job(input string tag,
                     input logic [N-1:0] a,
                     input int l, input int s, input int h,
                     input int poke,
                     output logic [N-1:0] got);
    logic [N-1:0] em;
    int ei, ee, ec, cyc;
    bit b1;
    lat = l;
    sing_at = s;
    hold_at = h;
    model(a, s, h, em, ei, ee);
    ec = 1 + ei * (l + 3);
    if (ee == 1) ec += l + 1;
    if (ee == 2) ec += INV_TMO;
    run(a, ident(), poke, cyc, b1);
    got = bus.o_mat;
    chk({tag, "_done"}, bus.o_done, 1);
    chk({tag, "_cycle"}, cyc, ec);
    chk({tag, "_busy1"}, b1, 1);
    chk({tag, "_iters"}, bus.o_iters, ei);
    chk({tag, "_err"}, bus.o_err, ee);
    chkm({tag, "_mat"}, bus.o_mat, em);
    chk({tag, "_busy_at_done"}, bus.o_busy, 0);
    chk({tag, "_req_at_done"}, bus.o_inv_req, 0);
    @(negedge iclk);
    chk({tag, "_pulse"}, bus.o_done, 0);
    chkm({tag, "_hold"}, bus.o_mat, em);
  endtask

  initial begin
    logic [N-1:0] a, got;
    checks = 0;
    errors = 0;
    lat = 1;
    sing_at = 0;
    hold_at = 0;
    bus.i_start = 1'b0;
    bus.i_mat = '0;
    ireset = 1'b0;
    repeat (2) @(negedge iclk);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_req", bus.o_inv_req, 0);
    chk("rst_err", bus.o_err, 0);
    chk("rst_iters", bus.o_iters, 0);
    chkm("rst_mat", bus.o_mat, '0);
    ireset = 1'b1;
    @(negedge iclk);

    a = ident();
    job("id64", a, 1, 0, 0, 0, got);
    chkm("id64_value", got, a);

    a = '0;
    for (int i = 0; i < 3; i++) put(a, i * 4, 256);
    job("diag256", a, 1, 0, 0, 0, got);
    for (int k = 0; k < 9; k++)
      if (k % 4 == 0)
        chk("diag256_range",
            el(got, k) >= 126 && el(got, k) <= 130, 1);
      else
        chk("diag256_offdiag", el(got, k), 0);

    a = ident();
    put(a, 1, -3);
    put(a, 3, -3);
    job("floor", a, 1, 0, 0, 0, got);
    chk("floor_a01", el(got, 1), -2);

    a = ident();
    put(a, 0, 100);
    put(a, 8, 150);
    put(a, 2, 7);
    put(a, 6, 7);
    job("timeout", a, 1, 0, 1, 0, got);
    chkm("timeout_is_a", got, a);

    a = '0;
    for (int i = 0; i < 3; i++) put(a, i * 4, 300);
    job("sing", a, 0, 2, 0, 3, got);

    for (int t = 0; t < 6; t++) begin
      a = '0;
      for (int i = 0; i < 3; i++) begin
        put(a, i * 4, $urandom_range(2000, 64));
        for (int j = i + 1; j < 3; j++) begin
          longint v;
          v = longint'($urandom_range(60, 0)) - 30;
          put(a, i * 3 + j, v);
          put(a, j * 3 + i, v);
        end
      end
      job($sformatf("rnd%0d", t), a,
          int'($urandom_range(3, 0)), 0, 0, 0, got);
    end

    lat = 0;
    sing_at = 0;
    hold_at = 1;
    bus.i_mat = ident();
    bus.i_start = 1'b1;
    @(negedge iclk);
    bus.i_start = 1'b0;
    repeat (2) @(negedge iclk);
    chk("midinv_req_before", bus.o_inv_req, 1);
    ireset = 1'b0;
    #1;
    chk("midrst_busy", bus.o_busy, 0);
    chk("midrst_req", bus.o_inv_req, 0);
    chk("midrst_done", bus.o_done, 0);
    chk("midrst_err", bus.o_err, 0);
    chk("midrst_iters", bus.o_iters, 0);
    chkm("midrst_mat", bus.o_mat, '0);
    chkm("midrst_inv_y", bus.o_inv_y, '0);
    @(negedge iclk);
    ireset = 1'b1;
    @(negedge iclk);
    a = '0;
    for (int i = 0; i < 3; i++) put(a, i * 4, 576);
    job("after_rst", a, 2, 0, 0, 0, got);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
